// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART TX FIFO write port between two byte requesters:
// port 0 is the monitor command/response path, port 1 the CPU console.
// Ownership is held for a whole packet so a requester's bytes reach the FIFO
// contiguously. Owners alternate between packets, and a burst cap releases
// an owner after MAX_BURST bytes so that one port cannot starve the other.
//
// Parameters:
//   MAX_BURST    bytes per grant before forced release (0 = unlimited)
//   TIMEOUT_CYC  idle-owner cycles before forced release (timeout build only)
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/data/last     byte offered by requester N, last marks packet end
//   reqN_ready               requester N byte accepted this cycle
//   tx_fifo_full             TX FIFO cannot accept a byte this cycle
//   tx_wdata, tx_wten        FIFO write data and one-cycle write strobe
//   grant                    one-hot current owner, 2'b00 when idle
//   timeout_err              one-cycle pulse when an idle owner is evicted
// Build option:
//   UART_ARB_TIMEOUT_EN      when defined, an owner that offers no byte for
//                            TIMEOUT_CYC cycles loses the grant. Otherwise an
//                            owner keeps the grant indefinitely and
//                            timeout_err is tied low.
//
// state | meaning
// IDLE  | no owner; picks the next owner, no data moves
// OWN0  | port 0 owns the FIFO write port
// OWN1  | port 1 owns the FIFO write port

module uart_tx_arbiter #(
    parameter int MAX_BURST   = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_fifo_full,
    output logic [7:0] tx_wdata,
    output logic       tx_wten,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int BW = ($clog2(MAX_BURST + 1) > 8) ? $clog2(MAX_BURST + 1) : 8;
    localparam logic [BW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            rr_armed;
    logic [BW-1:0]   burst_cnt;
    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;
    logic            xfer;
    logic            burst_hit;
    logic            timeout_hit;
    logic            release_now;

    // Owner mux; in IDLE everything reads as zero so no byte can move.
    always_comb begin
        own_valid = 1'b0;
        own_data  = 8'h00;
        own_last  = 1'b0;
        case (state)
            OWN0: begin
                own_valid = req0_valid;
                own_data  = req0_data;
                own_last  = req0_last;
            end
            OWN1: begin
                own_valid = req1_valid;
                own_data  = req1_data;
                own_last  = req1_last;
            end
            default: ;
        endcase
    end

    assign xfer        = own_valid && !tx_fifo_full;
    assign burst_hit   = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);
    assign release_now = (xfer && (own_last || burst_hit)) || timeout_hit;

    // rr_armed stays low until the first release so port 0 wins the first
    // contest after reset; afterwards the port not served last wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt = (rr_armed && !rr_ptr) ? OWN1 : OWN0;
                end else if (req0_valid) begin
                    state_nxt = OWN0;
                end else if (req1_valid) begin
                    state_nxt = OWN1;
                end
            end
            default: begin
                if (release_now) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst counter saturates rather than wrapping when MAX_BURST is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            rr_armed  <= 1'b0;
            burst_cnt <= '0;
        end else if (release_now) begin
            rr_ptr    <= (state == OWN1);
            rr_armed  <= 1'b1;
            burst_cnt <= '0;
        end else if (xfer && (burst_cnt != '1)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    assign req0_ready = xfer && (state == OWN0);
    assign req1_ready = xfer && (state == OWN1);
    assign tx_wten    = xfer;
    assign tx_wdata   = own_data;
    assign grant      = {state == OWN1, state == OWN0};

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT_CYC - 1);

    logic [15:0] idle_left;
    logic        owner_idle;

    // Only cycles with no byte offered count; a full FIFO stall holds the
    // counter because the owner is not at fault.
    assign owner_idle  = (state != IDLE) && !own_valid;
    assign timeout_hit = owner_idle && (idle_left == 16'h0000);
    assign timeout_err = timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_left <= IDLE_LOAD;
        end else if ((state == IDLE) || xfer || release_now) begin
            idle_left <= IDLE_LOAD;
        end else if (owner_idle) begin
            idle_left <= idle_left - 1'b1;
        end
    end
`else
    // TIMEOUT_CYC has no effect without the timeout feature.
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_fifo_full;
    logic [7:0] tx_wdata;
    logic       tx_wten;
    logic [1:0] grant;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    // Per-port byte streams presented by the requester drivers.
    logic [7:0] sdat  [2][64];
    logic       slast [2][64];
    int         slen  [2];
    int         sidx  [2];
    // Expected FIFO write order: {port, data}.
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .MAX_BURST   (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .tx_fifo_full (tx_fifo_full),
        .tx_wdata     (tx_wdata),
        .tx_wten      (tx_wten),
        .grant        (grant),
        .timeout_err  (timeout_err)
    );

    task automatic clear_streams();
        slen[0] = 0;
        slen[1] = 0;
        sidx[0] = 0;
        sidx[1] = 0;
    endtask

    task automatic load_byte(input int p, input logic [7:0] d, input logic l);
        sdat[p][slen[p]]  = d;
        slast[p][slen[p]] = l;
        slen[p]++;
    endtask

    // One clock of requester behaviour: drive at the falling edge, sample
    // 1 time unit later, and retire a byte on every valid&ready.
    task automatic drive_cycle(input logic full, input int gap_pct, input logic hold0, input logic hold1);
        logic v0;
        logic v1;
        @(negedge clk);
        tx_fifo_full = full;
        v0 = (sidx[0] < slen[0]) && !hold0;
        v1 = (sidx[1] < slen[1]) && !hold1;
        if (gap_pct > 0) begin
            if (v0 && grant[0] && (int'($urandom_range(0, 99)) < gap_pct)) v0 = 1'b0;
            if (v1 && grant[1] && (int'($urandom_range(0, 99)) < gap_pct)) v1 = 1'b0;
        end
        req0_valid = v0;
        req0_data  = v0 ? sdat[0][sidx[0]] : 8'h00;
        req0_last  = v0 && slast[0][sidx[0]];
        req1_valid = v1;
        req1_data  = v1 ? sdat[1][sidx[1]] : 8'h00;
        req1_last  = v1 && slast[1][sidx[1]];
        #1;
        if (req0_valid && req0_ready) sidx[0]++;
        if (req1_valid && req1_ready) sidx[1]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        req0_valid   = 1'b0;
        req0_data    = 8'h00;
        req0_last    = 1'b0;
        req1_valid   = 1'b0;
        req1_data    = 8'h00;
        req1_last    = 1'b0;
        tx_fifo_full = 1'b0;
        clear_streams();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        req0_valid   = 1'b1;
        req0_data    = 8'h5A;
        req0_last    = 1'b0;
        req1_valid   = 1'b1;
        req1_data    = 8'hA5;
        req1_last    = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req0_ready, req1_ready, tx_wten, tx_wdata, grant, timeout_err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got r0=%b r1=%b wten=%b wdata=%h grant=%b terr=%b want all zero",
                     req0_ready, req1_ready, tx_wten, tx_wdata, grant, timeout_err);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (grant !== 2'b00 || tx_wten !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got grant=%b wten=%b want 00/0", grant, tx_wten);
        end
    endtask

    task automatic test_single_packet();
        logic       ew [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ed [6] = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00, 8'h00};
        logic [1:0] eg [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        do_reset();
        load_byte(0, 8'h41, 1'b0);
        load_byte(0, 8'h42, 1'b0);
        load_byte(0, 8'h43, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b0);
            total++;
            if (tx_wten !== ew[i] || grant !== eg[i] || (ew[i] && tx_wdata !== ed[i])) begin
                bad++;
                $display("FAIL single_pkt cyc%0d got wten=%b grant=%b data=%h want wten=%b grant=%b data=%h",
                         i, tx_wten, grant, tx_wdata, ew[i], eg[i], ed[i]);
            end
        end
    endtask

    task automatic test_both_valid();
        logic       ew [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       e0 [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       e1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [7] = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1, 8'h00};
        logic [1:0] eg [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        load_byte(0, 8'hA0, 1'b0);
        load_byte(0, 8'hA1, 1'b1);
        load_byte(1, 8'hB0, 1'b0);
        load_byte(1, 8'hB1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b0);
            total++;
            if (tx_wten !== ew[i] || grant !== eg[i] || req0_ready !== e0[i] || req1_ready !== e1[i] ||
                (ew[i] && tx_wdata !== ed[i])) begin
                bad++;
                $display("FAIL both_valid cyc%0d got wten=%b grant=%b r0=%b r1=%b data=%h want %b/%b/%b/%b/%h",
                         i, tx_wten, grant, req0_ready, req1_ready, tx_wdata, ew[i], eg[i], e0[i], e1[i], ed[i]);
            end
        end
    endtask

    task automatic test_full_stall();
        logic       ew [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [11] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h00};
        logic [1:0] eg;
        do_reset();
        for (int b = 0; b < 4; b++) load_byte(0, 8'(8'h10 + b), b == 3);
        for (int i = 0; i < 11; i++) begin
            eg = (i == 0 || i == 10) ? 2'b00 : 2'b01;
            drive_cycle((i >= 2) && (i <= 6), 0, 1'b0, 1'b0);
            total++;
            if (tx_wten !== ew[i] || req0_ready !== ew[i] || grant !== eg || (ew[i] && tx_wdata !== ed[i])) begin
                bad++;
                $display("FAIL full_stall cyc%0d got wten=%b r0=%b grant=%b data=%h want wten=%b grant=%b data=%h",
                         i, tx_wten, req0_ready, grant, tx_wdata, ew[i], eg, ed[i]);
            end
        end
        total++;
        if (sidx[0] !== 4) begin
            bad++;
            $display("FAIL full_stall_count got=%0d bytes accepted want=4", sidx[0]);
        end
    endtask

    task automatic test_burst_cap();
        logic       ew [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [12] = '{8'h00, 8'h60, 8'h61, 8'h62, 8'h63, 8'h00, 8'h70, 8'h71, 8'h00, 8'h64, 8'h65, 8'h00};
        logic [1:0] eg [12] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        for (int b = 0; b < 6; b++) load_byte(1, 8'(8'h60 + b), b == 5);
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b0);
            total++;
            if (tx_wten !== ew[i] || grant !== eg[i] || (ew[i] && tx_wdata !== ed[i])) begin
                bad++;
                $display("FAIL burst_cap cyc%0d got wten=%b grant=%b data=%h want wten=%b grant=%b data=%h",
                         i, tx_wten, grant, tx_wdata, ew[i], eg[i], ed[i]);
            end
            if (i == 0) begin
                load_byte(0, 8'h70, 1'b0);
                load_byte(0, 8'h71, 1'b1);
            end
        end
    endtask

`ifndef UART_ARB_TIMEOUT_EN
    task automatic test_owner_stall();
        logic       ew;
        logic [7:0] ed;
        logic [1:0] eg;
        do_reset();
        load_byte(0, 8'h21, 1'b0);
        load_byte(0, 8'h22, 1'b0);
        load_byte(0, 8'h23, 1'b1);
        load_byte(1, 8'h31, 1'b1);
        for (int i = 0; i < 27; i++) begin
            ew = (i == 1) || (i == 22) || (i == 23) || (i == 25);
            ed = (i == 1) ? 8'h21 : (i == 22) ? 8'h22 : (i == 23) ? 8'h23 : 8'h31;
            eg = (i == 0 || i == 24 || i == 26) ? 2'b00 : (i == 25) ? 2'b10 : 2'b01;
            drive_cycle(1'b0, 0, (i >= 2) && (i <= 21), 1'b0);
            total++;
            if (tx_wten !== ew || grant !== eg || timeout_err !== 1'b0 || (ew && tx_wdata !== ed)) begin
                bad++;
                $display("FAIL owner_stall cyc%0d got wten=%b grant=%b terr=%b data=%h want wten=%b grant=%b terr=0 data=%h",
                         i, tx_wten, grant, timeout_err, tx_wdata, ew, eg, ed);
            end
        end
    endtask
`else
    task automatic test_timeout();
        logic       ew;
        logic       et;
        logic [7:0] ed;
        logic [1:0] eg;
        do_reset();
        load_byte(0, 8'h21, 1'b0);
        load_byte(0, 8'h22, 1'b1);
        load_byte(1, 8'h31, 1'b1);
        for (int i = 0; i < 15; i++) begin
            ew = (i == 1) || (i == 11) || (i == 13);
            et = (i == 9);
            ed = (i == 1) ? 8'h21 : (i == 11) ? 8'h31 : 8'h22;
            eg = (i == 0 || i == 10 || i == 12 || i == 14) ? 2'b00 : (i == 11) ? 2'b10 : 2'b01;
            drive_cycle(1'b0, 0, (i >= 2) && (i <= 9), 1'b0);
            total++;
            if (tx_wten !== ew || grant !== eg || timeout_err !== et || (ew && tx_wdata !== ed)) begin
                bad++;
                $display("FAIL timeout cyc%0d got wten=%b grant=%b terr=%b data=%h want wten=%b grant=%b terr=%b data=%h",
                         i, tx_wten, grant, timeout_err, tx_wdata, ew, eg, et, ed);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_packet();
        logic       ew [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [6] = '{8'h00, 8'hD0, 8'h00, 8'hC0, 8'hC1, 8'h00};
        logic [1:0] eg [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        for (int b = 0; b < 5; b++) load_byte(0, 8'(8'h50 + b), b == 4);
        repeat (4) drive_cycle(1'b0, 0, 1'b0, 1'b0);
        total++;
        if (tx_wten !== 1'b1 || tx_wdata !== 8'h52) begin
            bad++;
            $display("FAIL reset_mid_pre got wten=%b data=%h want 1/52", tx_wten, tx_wdata);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready, tx_wten, tx_wdata, grant, timeout_err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid_async got r0=%b r1=%b wten=%b wdata=%h grant=%b terr=%b want all zero",
                     req0_ready, req1_ready, tx_wten, tx_wdata, grant, timeout_err);
        end
        repeat (2) @(negedge clk);
        clear_streams();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        load_byte(1, 8'hC0, 1'b0);
        load_byte(1, 8'hC1, 1'b1);
        load_byte(0, 8'hD0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 0, 1'b0, 1'b0);
            total++;
            if (tx_wten !== ew[i] || grant !== eg[i] || (ew[i] && tx_wdata !== ed[i])) begin
                bad++;
                $display("FAIL reset_mid_restart cyc%0d got wten=%b grant=%b data=%h want wten=%b grant=%b data=%h",
                         i, tx_wten, grant, tx_wdata, ew[i], eg[i], ed[i]);
            end
        end
    endtask

    // Random packets on both ports, random FIFO-full and owner valid gaps.
    // The reference order comes from packet-level round robin: each grant
    // delivers the rest of the current packet, at most 4 bytes.
    task automatic test_random_stream(input int npk0, input int npk1, input int full_pct, input int gap_pct);
        int         npk [2];
        int         pos [2];
        int         last_srv;
        int         pick;
        int         n;
        int         len;
        int         cycles;
        bit         done;
        logic [1:0] prev_grant;
        logic [8:0] e;
        do_reset();
        exp_q.delete();
        npk[0] = npk0;
        npk[1] = npk1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < npk[p]; k++) begin
                len = $urandom_range(1, 7);
                for (int b = 0; b < len; b++) load_byte(p, 8'($urandom), b == len - 1);
            end
        end
        pos[0]   = 0;
        pos[1]   = 0;
        last_srv = -1;
        while (pos[0] < slen[0] || pos[1] < slen[1]) begin
            if (pos[0] < slen[0] && pos[1] < slen[1]) pick = (last_srv == 0) ? 1 : 0;
            else pick = (pos[0] < slen[0]) ? 0 : 1;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                exp_q.push_back({(pick == 1), sdat[pick][pos[pick] + n]});
                n++;
                if (slast[pick][pos[pick] + n - 1] || n == 4) done = 1'b1;
            end
            pos[pick] += n;
            last_srv = pick;
        end

        cycles     = 0;
        prev_grant = 2'b00;
        while ((sidx[0] < slen[0] || sidx[1] < slen[1]) && cycles < 3000) begin
            drive_cycle(int'($urandom_range(0, 99)) < full_pct, gap_pct, 1'b0, 1'b0);
            cycles++;
            total++;
            if (tx_wten && tx_fifo_full) begin
                bad++;
                $display("FAIL rand_overrun cyc%0d got wten=1 while full want wten=0", cycles);
            end
            total++;
            if ((req0_ready || req1_ready) !== tx_wten || (req0_ready && req1_ready)) begin
                bad++;
                $display("FAIL rand_ready cyc%0d got r0=%b r1=%b wten=%b", cycles, req0_ready, req1_ready, tx_wten);
            end
            total++;
            if (grant == 2'b11 || (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant) ||
                timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL rand_grant cyc%0d got grant=%b prev=%b terr=%b want one-hot with idle gap, terr=0",
                         cycles, grant, prev_grant, timeout_err);
            end
            prev_grant = grant;
            if (tx_wten) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra_write got port=%0d data=%h want no write", req1_ready, tx_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({req1_ready, tx_wdata} !== e) begin
                        bad++;
                        $display("FAIL rand_byte got port=%0d data=%h want port=%0d data=%h",
                                 req1_ready, tx_wdata, e[8], e[7:0]);
                    end
                end
            end
        end
        total++;
        if (cycles >= 3000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_complete got cycles=%0d left=%0d want finish with 0 bytes left", cycles, exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req0_valid   = 1'b0;
        req0_data    = 8'h00;
        req0_last    = 1'b0;
        req1_valid   = 1'b0;
        req1_data    = 8'h00;
        req1_last    = 1'b0;
        tx_fifo_full = 1'b0;
        clear_streams();
        test_reset();
        test_single_packet();
        test_both_valid();
        test_full_stall();
        test_burst_cap();
`ifndef UART_ARB_TIMEOUT_EN
        test_owner_stall();
`else
        test_timeout();
`endif
        test_reset_mid_packet();
        test_random_stream(4, 4, 20, 15);
        test_random_stream(5, 2, 40, 0);
        test_random_stream(0, 3, 10, 20);
        test_random_stream(3, 5, 30, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
